tinker_data_mem: RTL

//  Parametrised, handshaked data memory for the Tinker core (multi-cycle successor to the

---
 rtl/tinker_data_mem_pkg.sv | 5 +
 rtl/tinker_data_mem_if.sv | 17 +
 rtl/tinker_mem_array.sv | 23 ++
 rtl/tinker_data_mem.sv | 106 ++++++++++
 4 files changed

// File: rtl/tinker_data_mem_pkg.sv
// tinker_pkg: shared types and defaults for the Tinker data memory.
package tinker_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
   localparam int TINKER_MEM_SIZE = 524288;
endpackage

// File: rtl/tinker_data_mem_if.sv
// tinker_data_mem_if: request/response valid-ready channel of the Tinker data memory.
interface tinker_data_mem_if #(parameter int ADDR_W = 32, parameter int DATA_BYTES = 8);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_W-1:0]       req_addr;
   logic [8*DATA_BYTES-1:0] req_wdata;
   logic [DATA_BYTES-1:0]   req_bmask;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [8*DATA_BYTES-1:0] rsp_rdata;
   logic                    rsp_err;
   modport master (output req_valid, req_write, req_addr, req_wdata, req_bmask, rsp_ready,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_bmask, rsp_ready,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/tinker_mem_array.sv
// tinker_mem_array: byte storage with per-byte write enables and a combinational
// little-endian multi-byte read port.
module tinker_mem_array #(
   parameter int MEM_SIZE   = 524288,
   parameter int DATA_BYTES = 8,
   parameter int IDX_W      = $clog2(MEM_SIZE)
) (
   input  logic                    clk,
   input  logic [DATA_BYTES-1:0]   we,
   input  logic [IDX_W-1:0]        waddr,
   input  logic [8*DATA_BYTES-1:0] wdata,
   input  logic [IDX_W-1:0]        raddr,
   output logic [8*DATA_BYTES-1:0] rdata
);
   logic [7:0] mem [MEM_SIZE];
   always_ff @(posedge clk) begin
      for (int i = 0; i < DATA_BYTES; i++)
         if (we[i]) mem[waddr + IDX_W'(i)] <= wdata[8*i +: 8];
   end
   for (genvar g = 0; g < DATA_BYTES; g++) begin : g_rd
      assign rdata[8*g +: 8] = mem[raddr + IDX_W'(g)];
   end
endmodule

// File: rtl/tinker_data_mem.sv
// tinker_data_mem: handshaked fixed-latency data memory; stores commit at accept.
// Optional TINKER_DMEM_BYTEMASK_EN restricts stores to bytes selected by req_bmask.
module tinker_data_mem
   import tinker_pkg::*;
#(
   parameter int MEM_SIZE   = TINKER_MEM_SIZE,
   parameter int ADDR_W     = 32,
   parameter int DATA_BYTES = 8,
   parameter int LATENCY    = 2
) (
   input logic clk,
   input logic reset,
   tinker_data_mem_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_SIZE);
   localparam int DW    = 8 * DATA_BYTES;
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

   dmem_state_t           state;
   logic [CNT_W-1:0]      cnt;
   logic                  write_q, err_q, req_ready, rsp_valid, rsp_err;
   logic [ADDR_W-1:0]     addr_q;
   logic [DW-1:0]         rsp_rdata, rd_data, resp_data;
   logic [ADDR_W:0]       end_addr;
   logic [DATA_BYTES-1:0] mask, we;
   logic                  accept, oob, cur_write, cur_err;

   // end address kept one bit wider so addresses near the top cannot wrap into range
   assign end_addr  = {1'b0, bus.req_addr} + (ADDR_W+1)'(DATA_BYTES);
   assign oob       = end_addr > (ADDR_W+1)'(MEM_SIZE);
   assign accept    = bus.req_valid && req_ready;
`ifdef TINKER_DMEM_BYTEMASK_EN
   assign mask      = bus.req_bmask;
`else
   logic unused_bmask;
   assign unused_bmask = ^bus.req_bmask;
   assign mask      = '1;
`endif
   assign we        = (accept && bus.req_write && !oob) ? mask : '0;
   assign cur_write = state == IDLE ? bus.req_write : write_q;
   assign cur_err   = state == IDLE ? oob : err_q;
   assign resp_data = (cur_write || cur_err) ? '0 : rd_data;

   tinker_mem_array #(.MEM_SIZE(MEM_SIZE), .DATA_BYTES(DATA_BYTES)) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (IDX_W'(bus.req_addr)),
      .wdata (bus.req_wdata),
      .raddr (IDX_W'(state == IDLE ? bus.req_addr : addr_q)),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               write_q   <= bus.req_write;
               err_q     <= oob;
               addr_q    <= bus.req_addr;
               req_ready <= 1'b0;
               cnt       <= CNT_INIT;
               if (LATENCY == 1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= resp_data;
                  rsp_err   <= cur_err;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: if (cnt == '0) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= resp_data;
               rsp_err   <= cur_err;
            end else begin
               cnt <= cnt - 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_err   = rsp_err;
endmodule
